// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, loads reset/interrupt vectors from
// the unified memory and registers one IF/ID stage for decode.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [3:0] IMM_OPCODE = 4'hC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              intr_req,
  input  logic              rti,
  input  logic [DATA_W-1:0] instr_out,
  input  logic [DATA_W-1:0] immediate,
  input  logic              immediate_enabled,
  output logic [ADDR_W-1:0] addr_instr,
  output logic              intr_ack,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_imm,
  output logic              if_imm_en,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_next,
  output logic [ADDR_W-1:0] intr_ret_pc,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_RST_VEC = 2'd0,
    S_RUN     = 2'd1,
    S_INT_VEC = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              mask, mask_n;
  logic              valid_n;
  logic [DATA_W-1:0] instr_n, imm_n;
  logic              imm_en_n;
  logic [ADDR_W-1:0] ipc_n, ipc_next_n, ret_n;
  logic [ADDR_W-1:0] step_len;
  logic [ADDR_W-1:0] pc_seq;

  assign fsm_state = state;

  // Two-byte instructions advance past their immediate; arithmetic wraps at 2**ADDR_W.
  assign step_len = immediate_enabled ? ADDR_W'(2) : ADDR_W'(1);
  assign pc_seq   = pc + step_len;

  always_comb begin
    state_next = state;
    pc_n       = pc;
    mask_n     = rti ? 1'b0 : mask;
    valid_n    = if_valid;
    instr_n    = if_instr;
    imm_n      = if_imm;
    imm_en_n   = if_imm_en;
    ipc_n      = if_pc;
    ipc_next_n = if_pc_next;
    ret_n      = intr_ret_pc;
    addr_instr = pc;
    intr_ack   = 1'b0;

    case (state)
      S_RST_VEC: begin
        addr_instr = '0;
        pc_n       = ADDR_W'(instr_out);
        valid_n    = 1'b0;
        state_next = S_RUN;
      end
      S_INT_VEC: begin
        // Memory substitutes mem[1] for the addressed byte while intr_ack is high.
        intr_ack   = 1'b1;
        pc_n       = ADDR_W'(instr_out);
        valid_n    = 1'b0;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (branch_taken) begin
          pc_n    = branch_target;
          valid_n = 1'b0;
        end else if (intr_req && !mask && !stall) begin
          ret_n      = pc;
          mask_n     = 1'b1;
          valid_n    = 1'b0;
          state_next = S_INT_VEC;
        end else if (!stall) begin
          instr_n    = instr_out;
          imm_n      = immediate_enabled ? immediate : '0;
          imm_en_n   = immediate_enabled;
          ipc_n      = pc;
          ipc_next_n = pc_seq;
          valid_n    = 1'b1;
          pc_n       = pc_seq;
        end
      end
      default: begin
        state_next = S_RST_VEC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST_VEC;
      pc          <= '0;
      mask        <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_imm      <= '0;
      if_imm_en   <= 1'b0;
      if_pc       <= '0;
      if_pc_next  <= '0;
      intr_ret_pc <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_n;
      mask        <= mask_n;
      if_valid    <= valid_n;
      if_instr    <= instr_n;
      if_imm      <= imm_n;
      if_imm_en   <= imm_en_n;
      if_pc       <= ipc_n;
      if_pc_next  <= ipc_next_n;
      intr_ret_pc <= ret_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory + reference model, directed checks
// of the documented scenarios, then randomized control stimulus.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       intr_req;
  logic       rti;
  logic [7:0] instr_out;
  logic [7:0] immediate;
  logic       immediate_enabled;
  logic [7:0] addr_instr;
  logic       intr_ack;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic       if_imm_en;
  logic [7:0] if_pc;
  logic [7:0] if_pc_next;
  logic [7:0] intr_ret_pc;
  logic [1:0] fsm_state;

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference model state
  localparam int M_RUN = 0, M_RSTVEC = 1, M_INTVEC = 2;
  int m_mode, m_pc, m_mask, m_valid, m_instr, m_imm, m_imm_en;
  int m_ipc, m_ipc_next, m_ret;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .intr_req(intr_req), .rti(rti),
    .instr_out(instr_out), .immediate(immediate),
    .immediate_enabled(immediate_enabled), .addr_instr(addr_instr),
    .intr_ack(intr_ack), .if_valid(if_valid), .if_instr(if_instr),
    .if_imm(if_imm), .if_imm_en(if_imm_en), .if_pc(if_pc),
    .if_pc_next(if_pc_next), .intr_ret_pc(intr_ret_pc), .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unified memory
  always_comb begin
    instr_out         = intr_ack ? mem[1] : mem[addr_instr];
    immediate         = mem[8'(addr_instr + 8'd1)];
    immediate_enabled = (instr_out[7:4] == 4'hC);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_step();
    int op, len;
    if (rst) begin
      m_mode = M_RSTVEC; m_pc = 0; m_mask = 0; m_valid = 0; m_instr = 0;
      m_imm = 0; m_imm_en = 0; m_ipc = 0; m_ipc_next = 0; m_ret = 0;
      return;
    end
    if (m_mode == M_RSTVEC) begin
      m_pc = mem[0]; m_valid = 0; m_mode = M_RUN;
      if (rti) m_mask = 0;
    end else if (m_mode == M_INTVEC) begin
      m_pc = mem[1]; m_valid = 0; m_mode = M_RUN;
      if (rti) m_mask = 0;
    end else begin
      op  = mem[m_pc];
      len = ((op / 16) == 12) ? 2 : 1;
      if (branch_taken) begin
        m_pc = branch_target; m_valid = 0;
        if (rti) m_mask = 0;
      end else if (intr_req && m_mask == 0 && !stall) begin
        m_ret = m_pc; m_mask = 1; m_valid = 0; m_mode = M_INTVEC;
      end else begin
        if (rti) m_mask = 0;
        if (!stall) begin
          m_instr    = op;
          m_imm      = (len == 2) ? mem[(m_pc + 1) % 256] : 0;
          m_imm_en   = (len == 2) ? 1 : 0;
          m_ipc      = m_pc;
          m_ipc_next = (m_pc + len) % 256;
          m_pc       = (m_pc + len) % 256;
          m_valid    = 1;
        end
      end
    end
  endtask

  // Compare process: every negedge once the first reset edge has happened
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr_instr", addr_instr, (m_mode == M_RSTVEC) ? 0 : m_pc);
      chk("intr_ack", intr_ack, (m_mode == M_INTVEC) ? 1 : 0);
      chk("if_valid", if_valid, m_valid);
      chk("if_instr", if_instr, m_instr);
      chk("if_imm", if_imm, m_imm);
      chk("if_imm_en", if_imm_en, m_imm_en);
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc_next", if_pc_next, m_ipc_next);
      chk("intr_ret_pc", intr_ret_pc, m_ret);
    end
  end

  // Driver: one rising edge, update the model, then let inputs change at +2
  task automatic step();
    @(posedge clk);
    model_step();
    chk_en = 1;
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    intr_req = 1'b0; rti = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) mem[i][7:4] = 4'hC;
    end
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
    mem[8'h10] = 8'hC3; mem[8'h11] = 8'h55; mem[8'h12] = 8'h20;
    mem[8'h40] = 8'h01; mem[8'hFF] = 8'h01;

    repeat (3) step();
    chk("lit_reset_valid", if_valid, 0);
    chk("lit_reset_pc_next", if_pc_next, 0);
    rst = 1'b0;
    #1;
    chk("lit_cyc1_addr", addr_instr, 8'h00);
    step();
    chk("lit_cyc2_addr", addr_instr, 8'h10);
    chk("lit_cyc2_valid", if_valid, 0);
    step();
    chk("lit_cyc3_valid", if_valid, 1);
    chk("lit_cyc3_instr", if_instr, 8'hC3);
    chk("lit_cyc3_imm", if_imm, 8'h55);
    chk("lit_cyc3_imm_en", if_imm_en, 1);
    chk("lit_cyc3_pc", if_pc, 8'h10);
    chk("lit_cyc3_pc_next", if_pc_next, 8'h12);
    step();
    chk("lit_cyc4_pc", if_pc, 8'h12);
    chk("lit_cyc4_instr", if_instr, 8'h20);
    chk("lit_cyc4_imm", if_imm, 8'h00);
    chk("lit_cyc4_addr", addr_instr, 8'h13);

    intr_req = 1'b1;
    step();
    chk("lit_intr_ack", intr_ack, 1);
    chk("lit_intr_ret", intr_ret_pc, 8'h13);
    chk("lit_intr_valid", if_valid, 0);
    step();
    chk("lit_intr_vec_addr", addr_instr, 8'h80);
    chk("lit_intr_ack_drop", intr_ack, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_masked_ack", intr_ack, 0);
    end
    rti = 1'b1;
    step();
    rti = 1'b0;
    chk("lit_rti_edge_ack", intr_ack, 0);
    step();
    chk("lit_reenter_ack", intr_ack, 1);
    intr_req = 1'b0;
    step();
    chk("lit_reenter_addr", addr_instr, 8'h80);

    branch_taken = 1'b1; branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    chk("lit_branch_valid", if_valid, 0);
    chk("lit_branch_addr", addr_instr, 8'h40);
    step();
    chk("lit_branch_pc", if_pc, 8'h40);
    chk("lit_branch_fetch_valid", if_valid, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_stall_addr", addr_instr, 8'h41);
      chk("lit_stall_pc", if_pc, 8'h40);
      chk("lit_stall_valid", if_valid, 1);
    end
    stall = 1'b0;

    branch_taken = 1'b1; branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    chk("lit_wrap_pre_addr", addr_instr, 8'hFF);
    step();
    chk("lit_wrap_addr", addr_instr, 8'h00);
    chk("lit_wrap_pc", if_pc, 8'hFF);
    chk("lit_wrap_pc_next", if_pc_next, 8'h00);

    rti = 1'b1;
    step();
    rti = 1'b0;
    intr_req = 1'b1;
    step();
    chk("lit_intvec_entry", intr_ack, 1);
    rst = 1'b1;
    step();
    intr_req = 1'b0;
    chk("lit_rst_ack", intr_ack, 0);
    chk("lit_rst_addr", addr_instr, 8'h00);
    chk("lit_rst_valid", if_valid, 0);
    chk("lit_rst_instr", if_instr, 0);
    chk("lit_rst_ret", intr_ret_pc, 0);
    chk("lit_rst_pc_next", if_pc_next, 0);
    step();
    rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 149) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = 8'($urandom_range(0, 255));
      rti           = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) intr_req = ~intr_req;
      step();
    end

    chk_en = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
